// File: rtl/punc_datapath_pkg.sv
// Shared encodings for the PUnC control FSM and datapath: mux selects,
// ALU opcodes and the condition-code reset value.
package punc_datapath_pkg;

  typedef enum logic [1:0] {
    ADDR_PC     = 2'b00,
    ADDR_ALU    = 2'b01,
    ADDR_STORE  = 2'b10,
    ADDR_PC_ALT = 2'b11
  } addr_sel_e;

  typedef enum logic [1:0] {
    WRF_PC      = 2'b00,
    WRF_MEM     = 2'b01,
    WRF_ALU     = 2'b10,
    WRF_ALU_ALT = 2'b11
  } wrf_sel_e;

  typedef enum logic [1:0] {
    SEXT_IMM5  = 2'b00,
    SEXT_OFF6  = 2'b01,
    SEXT_OFF9  = 2'b10,
    SEXT_OFF11 = 2'b11
  } sext_sel_e;

  typedef enum logic {A_PC = 1'b0, A_RF0 = 1'b1} a_sel_e;
  typedef enum logic {B_RF1 = 1'b0, B_SEXT = 1'b1} b_sel_e;
  typedef enum logic {PCD_ADDER = 1'b0, PCD_RF0 = 1'b1} pc_data_sel_e;
  typedef enum logic {PCA_OFF11 = 1'b0, PCA_OFF9 = 1'b1} pc_add_sel_e;
  typedef enum logic {NZP_ALU = 1'b0, NZP_MEM = 1'b1} nzp_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_AND    = 2'b01,
    ALU_PASS_A = 2'b10,
    ALU_NOT    = 2'b11
  } alu_op_e;

  localparam logic [2:0] NZP_RESET = 3'b010;

  // One-hot {negative, zero, positive} classification of a 16-bit value.
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    return {v[15], v == 16'h0000, !v[15] && (v != 16'h0000)};
  endfunction

endpackage

// File: rtl/punc_datapath_alu.sv
// Combinational PUnC ALU: ADD, AND, pass-through of A, and bitwise NOT of A.
module punc_alu
  import punc_datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_alu_sel,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = i_a;
    case (alu_op_e'(i_alu_sel))
      ALU_ADD:    o_result = i_a + i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_PASS_A: o_result = i_a;
      ALU_NOT:    o_result = ~i_a;
    endcase
  end

endmodule

// File: rtl/punc_datapath.sv
// PUnC LC3 datapath: PC, IR, NZP and indirect-address registers plus the
// ALU, sign extension, PC adder and routing muxes, steered by control strobes.
module punc_datapath
  import punc_datapath_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pc_clr,
  input  logic             i_pc_ld,
  input  logic             i_pc_inc,
  input  logic             i_pc_data_sel,
  input  logic             i_pc_add_sel,
  input  logic             i_ir_ld,
  input  logic             i_store_ld,
  input  logic [1:0]       i_addr_mem_sel,
  input  logic [1:0]       i_w_rf_sel,
  input  logic [1:0]       i_sext_sel,
  input  logic             i_a_sel,
  input  logic             i_b_sel,
  input  logic [1:0]       i_alu_sel,
  input  logic             i_nzp_sel,
  input  logic             i_n_ld,
  input  logic             i_z_ld,
  input  logic             i_p_ld,
  input  logic [WIDTH-1:0] i_mem_r_data,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_w_data,
  input  logic [WIDTH-1:0] i_rf_r_data_0,
  input  logic [WIDTH-1:0] i_rf_r_data_1,
  output logic [WIDTH-1:0] o_rf_w_data,
  output logic [WIDTH-1:0] o_ir,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_n,
  output logic             o_z,
  output logic             o_p
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_store;
  logic             r_n;
  logic             r_z;
  logic             r_p;

  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_pc_off;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_nzp_src;
  logic [2:0]       w_nzp_flags;

  always_comb begin
    w_sext = {{(WIDTH-5){r_ir[4]}}, r_ir[4:0]};
    case (sext_sel_e'(i_sext_sel))
      SEXT_IMM5:  w_sext = {{(WIDTH-5){r_ir[4]}}, r_ir[4:0]};
      SEXT_OFF6:  w_sext = {{(WIDTH-6){r_ir[5]}}, r_ir[5:0]};
      SEXT_OFF9:  w_sext = {{(WIDTH-9){r_ir[8]}}, r_ir[8:0]};
      SEXT_OFF11: w_sext = {{(WIDTH-11){r_ir[10]}}, r_ir[10:0]};
    endcase
  end

  // The PC adder has its own offset extraction so a branch target can be
  // formed while the shared sign extender feeds the ALU.
  assign w_pc_off  = (pc_add_sel_e'(i_pc_add_sel) == PCA_OFF9)
                   ? {{(WIDTH-9){r_ir[8]}}, r_ir[8:0]}
                   : {{(WIDTH-11){r_ir[10]}}, r_ir[10:0]};
  assign w_pc_next = (pc_data_sel_e'(i_pc_data_sel) == PCD_RF0)
                   ? i_rf_r_data_0 : (r_pc + w_pc_off);

  assign w_alu_a = (a_sel_e'(i_a_sel) == A_RF0) ? i_rf_r_data_0 : r_pc;
  assign w_alu_b = (b_sel_e'(i_b_sel) == B_SEXT) ? w_sext : i_rf_r_data_1;

  punc_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a       (w_alu_a),
    .i_b       (w_alu_b),
    .i_alu_sel (i_alu_sel),
    .o_result  (w_alu_result)
  );

  always_comb begin
    o_mem_addr = r_pc;
    case (addr_sel_e'(i_addr_mem_sel))
      ADDR_PC:     o_mem_addr = r_pc;
      ADDR_ALU:    o_mem_addr = w_alu_result;
      ADDR_STORE:  o_mem_addr = r_store;
      ADDR_PC_ALT: o_mem_addr = r_pc;
    endcase
  end

  always_comb begin
    o_rf_w_data = r_pc;
    case (wrf_sel_e'(i_w_rf_sel))
      WRF_PC:      o_rf_w_data = r_pc;
      WRF_MEM:     o_rf_w_data = i_mem_r_data;
      WRF_ALU:     o_rf_w_data = w_alu_result;
      WRF_ALU_ALT: o_rf_w_data = w_alu_result;
    endcase
  end

  assign w_nzp_src   = (nzp_sel_e'(i_nzp_sel) == NZP_MEM) ? i_mem_r_data : w_alu_result;
  assign w_nzp_flags = nzp_of(w_nzp_src);

  // Reset wins over every strobe; each flag loads independently so partial
  // NZP loads behave bitwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc              <= RESET_PC;
      r_ir              <= '0;
      r_store           <= '0;
      {r_n, r_z, r_p}   <= NZP_RESET;
    end else begin
      if (i_pc_clr)      r_pc <= RESET_PC;
      else if (i_pc_ld)  r_pc <= w_pc_next;
      else if (i_pc_inc) r_pc <= r_pc + ONE;
      if (i_ir_ld)    r_ir    <= i_mem_r_data;
      if (i_store_ld) r_store <= i_mem_r_data;
      if (i_n_ld)     r_n     <= w_nzp_flags[2];
      if (i_z_ld)     r_z     <= w_nzp_flags[1];
      if (i_p_ld)     r_p     <= w_nzp_flags[0];
    end
  end

  assign o_mem_w_data = i_rf_r_data_1;
  assign o_ir         = r_ir;
  assign o_pc         = r_pc;
  assign o_n          = r_n;
  assign o_z          = r_z;
  assign o_p          = r_p;

endmodule

// File: tb/tb_punc_datapath.sv
// Directed bench for punc_datapath: an instruction-level reference model is
// compared every cycle, with literal expectations pinning key scenarios.
module tb_punc_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcClr, pcLd, pcInc, pcDataSel, pcAddSel, irLd, storeLd;
  logic [1:0]  addrMemSel, wRfSel, sextSel, aluSel;
  logic        aSel, bSel, nzpSel, nLd, zLd, pLd;
  logic [15:0] memRData, rf0, rf1;
  logic [15:0] memAddr, memWData, rfWData, irOut, pcOut;
  logic        nOut, zOut, pOut;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  logic [15:0] mPc, mIr, mStore;
  logic [2:0]  mNzp;

  always #5 clk = ~clk;

  punc_datapath #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .i_pc_clr(pcClr), .i_pc_ld(pcLd), .i_pc_inc(pcInc),
    .i_pc_data_sel(pcDataSel), .i_pc_add_sel(pcAddSel),
    .i_ir_ld(irLd), .i_store_ld(storeLd),
    .i_addr_mem_sel(addrMemSel), .i_w_rf_sel(wRfSel), .i_sext_sel(sextSel),
    .i_a_sel(aSel), .i_b_sel(bSel), .i_alu_sel(aluSel),
    .i_nzp_sel(nzpSel), .i_n_ld(nLd), .i_z_ld(zLd), .i_p_ld(pLd),
    .i_mem_r_data(memRData), .o_mem_addr(memAddr), .o_mem_w_data(memWData),
    .i_rf_r_data_0(rf0), .i_rf_r_data_1(rf1), .o_rf_w_data(rfWData),
    .o_ir(irOut), .o_pc(pcOut), .o_n(nOut), .o_z(zOut), .o_p(pOut)
  );

  // Signed interpretation of the low 'bits' bits of v, widened to 16 bits.
  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    int val;
    val = int'(v) & ((1 << bits) - 1);
    if (v[bits-1]) val = val - (1 << bits);
    return 16'(val);
  endfunction

  function automatic logic [15:0] modelAlu();
    int sextBits [4] = '{5, 6, 9, 11};
    logic [15:0] a, b;
    a = aSel ? rf0 : mPc;
    b = bSel ? sx(mIr, sextBits[sextSel]) : rf1;
    case (aluSel)
      2'd0:    return a + b;
      2'd1:    return a & b;
      2'd2:    return a;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [15:0] modelMemAddr();
    if (addrMemSel == 2'd1) return modelAlu();
    if (addrMemSel == 2'd2) return mStore;
    return mPc;
  endfunction

  function automatic logic [15:0] modelRfW();
    if (wRfSel == 2'd0) return mPc;
    if (wRfSel == 2'd1) return memRData;
    return modelAlu();
  endfunction

  function automatic logic [2:0] classify(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0000)  return 3'b010;
    return 3'b001;
  endfunction

  // Reference state advances on every rising edge from the sampled strobes.
  always @(posedge clk) begin
    logic [15:0] nextPc, v;
    logic [2:0]  f;
    if (rst) begin
      mPc = 16'h0000; mIr = 16'h0000; mStore = 16'h0000; mNzp = 3'b010;
    end else begin
      v  = nzpSel ? memRData : modelAlu();
      f  = classify(v);
      nextPc = pcDataSel ? rf0 : mPc + sx(mIr, pcAddSel ? 9 : 11);
      if (pcClr)      mPc = 16'h0000;
      else if (pcLd)  mPc = nextPc;
      else if (pcInc) mPc = mPc + 16'd1;
      if (irLd)    mIr = memRData;
      if (storeLd) mStore = memRData;
      if (nLd) mNzp[2] = f[2];
      if (zLd) mNzp[1] = f[1];
      if (pLd) mNzp[0] = f[0];
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_mem_addr", memAddr, modelMemAddr());
      checkOutput("model_rf_w_data", rfWData, modelRfW());
      checkOutput("model_mem_w_data", memWData, rf1);
      checkOutput("model_ir", irOut, mIr);
      checkOutput("model_pc", pcOut, mPc);
      checkOutput("model_nzp", {13'b0, nOut, zOut, pOut}, {13'b0, mNzp});
    end
  end

  // One clock edge, then drop every one-shot strobe; selects persist.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst = 0; pcClr = 0; pcLd = 0; pcInc = 0; irLd = 0; storeLd = 0;
    nLd = 0; zLd = 0; pLd = 0;
  endtask

  function automatic logic [15:0] nzpWord();
    return {13'b0, nOut, zOut, pOut};
  endfunction

  initial begin
    rst = 1; pcClr = 0; pcLd = 0; pcInc = 0; pcDataSel = 0; pcAddSel = 0;
    irLd = 0; storeLd = 0; addrMemSel = 0; wRfSel = 0; sextSel = 0;
    aSel = 0; bSel = 0; aluSel = 0; nzpSel = 0; nLd = 0; zLd = 0; pLd = 0;
    memRData = 0; rf0 = 0; rf1 = 16'h5A5A;

    applyStimulus();
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_pc", pcOut, 16'h0000);
    checkOutput("reset_ir", irOut, 16'h0000);
    checkOutput("reset_nzp", nzpWord(), 16'h0002);

    pcClr = 1; pcLd = 1; pcDataSel = 1; rf0 = 16'h1234;
    applyStimulus();
    @(negedge clk);
    checkOutput("clr_over_ld", pcOut, 16'h0000);

    pcLd = 1; rf0 = 16'h0005;
    applyStimulus();
    memRData = 16'h1283; irLd = 1; pcInc = 1; addrMemSel = 2'b00;
    @(negedge clk);
    checkOutput("fetch_addr", memAddr, 16'h0005);
    applyStimulus();
    @(negedge clk);
    checkOutput("fetch_ir", irOut, 16'h1283);
    checkOutput("fetch_pc", pcOut, 16'h0006);

    rf0 = 16'hFFFE; aSel = 1; bSel = 1; sextSel = 2'b00; aluSel = 2'b00;
    wRfSel = 2'b10; nzpSel = 0; nLd = 1; zLd = 1; pLd = 1;
    @(negedge clk);
    checkOutput("add_imm", rfWData, 16'h0001);
    applyStimulus();
    @(negedge clk);
    checkOutput("add_nzp", nzpWord(), 16'h0001);

    memRData = 16'h01FC; irLd = 1; pcDataSel = 1; rf0 = 16'h0010; pcLd = 1;
    applyStimulus();
    pcDataSel = 0; pcAddSel = 1; pcLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("branch_back", pcOut, 16'h000C);

    memRData = 16'h0001; irLd = 1; pcDataSel = 1; rf0 = 16'hFFFF; pcLd = 1;
    applyStimulus();
    pcDataSel = 0; pcAddSel = 1; pcLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("branch_wrap", pcOut, 16'h0000);

    memRData = 16'h0400; irLd = 1; pcDataSel = 1; rf0 = 16'h1000; pcLd = 1;
    applyStimulus();
    pcDataSel = 0; pcAddSel = 0; pcLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("jsr_off11", pcOut, 16'h0C00);

    pcDataSel = 1; rf0 = 16'h2222; pcLd = 1; pcInc = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("ld_over_inc", pcOut, 16'h2222);

    memRData = 16'h3000; storeLd = 1;
    applyStimulus();
    addrMemSel = 2'b10;
    @(negedge clk);
    checkOutput("ldi_addr", memAddr, 16'h3000);
    memRData = 16'h8000; nzpSel = 1; nLd = 1; zLd = 1; pLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("ldi_nzp", nzpWord(), 16'h0004);

    memRData = 16'h0000; zLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("partial_z", nzpWord(), 16'h0006);
    memRData = 16'h0005; pLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("partial_p", nzpWord(), 16'h0007);
    nLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("partial_n", nzpWord(), 16'h0003);

    memRData = 16'hABCD; irLd = 1; storeLd = 1;
    applyStimulus();
    addrMemSel = 2'b10;
    @(negedge clk);
    checkOutput("dual_ir", irOut, 16'hABCD);
    checkOutput("dual_store", memAddr, 16'hABCD);

    // Sweep every ALU op against each address/write-back route.
    for (int op = 0; op < 4; op++) begin
      for (int route = 0; route < 4; route++) begin
        aluSel = 2'(op); addrMemSel = 2'(route); wRfSel = 2'(3 - route);
        sextSel = 2'(route); aSel = route[0]; bSel = route[1];
        rf0 = 16'(16'h1357 * (op + 1)); rf1 = 16'(16'hF0F1 + route * 16'h0111);
        memRData = 16'(16'h8421 ^ (op * 16'h0F0F));
        nzpSel = 0; nLd = 1; zLd = 1; pLd = 1;
        applyStimulus();
      end
    end

    rf0 = 16'h00FF; rf1 = 16'h1234; aluSel = 2'b11; aSel = 1; bSel = 0; wRfSel = 2'b10;
    @(negedge clk);
    checkOutput("not_a", rfWData, 16'hFF00);

    pcDataSel = 1; pcLd = 1; rf0 = 16'h4000;
    applyStimulus();
    @(negedge clk);
    checkOutput("jmp_pc", pcOut, 16'h4000);

    rst = 1; pcLd = 1; rf0 = 16'h1234; irLd = 1; memRData = 16'h5555;
    nzpSel = 1; nLd = 1; zLd = 1; pLd = 1;
    applyStimulus();
    @(negedge clk);
    checkOutput("rst_over_ld_pc", pcOut, 16'h0000);
    checkOutput("rst_over_ld_ir", irOut, 16'h0000);
    checkOutput("rst_over_ld_nzp", nzpWord(), 16'h0002);

    @(posedge clk);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/punc_datapath.md
Name: punc_datapath

Overview:
- Datapath for the PUnC LC3 processor. Sits directly downstream of the PUnC control FSM and is driven by its select, load and clear strobes.
- Holds the architectural PC, IR, NZP condition codes and the indirect-address (store) register.
- Contains the ALU, sign-extension, PC adder and all routing muxes.
- Memory and register file sit outside this block. It drives their address and data ports and returns IR and n/z/p to control.

Parameters:
- WIDTH, 16, data/address width. Fixed by the ISA; only 16 is supported.
- RESET_PC, 16'h0000, PC value after reset or pc_clr.

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- pc_clr, input, 1, PC <= RESET_PC
- pc_ld, input, 1, PC <= PC mux
- pc_inc, input, 1, PC <= PC+1
- pc_data_sel, input, 1, PC mux: 0 = PC adder, 1 = rf_r_data_0 (JMP/RET)
- pc_add_sel, input, 1, PC adder offset: 0 = sext(IR[10:0]), 1 = sext(IR[8:0])
- ir_ld, input, 1, IR <= mem_r_data
- store_ld, input, 1, store register <= mem_r_data
- addr_mem_sel, input, 2, 00 = PC, 01 = ALU result, 10 = store register, 11 = PC
- w_rf_sel, input, 2, 00 = PC, 01 = mem_r_data, 10 = ALU result, 11 = ALU result
- sext_sel, input, 2, 00 = imm5 IR[4:0], 01 = off6 IR[5:0], 10 = off9 IR[8:0], 11 = off11 IR[10:0]
- a_sel, input, 1, ALU A: 0 = PC, 1 = rf_r_data_0
- b_sel, input, 1, ALU B: 0 = rf_r_data_1, 1 = sext value
- alu_sel, input, 2, 00 = ADD, 01 = AND, 10 = PASS_A, 11 = NOT A
- nzp_sel, input, 1, NZP source: 0 = ALU result, 1 = mem_r_data
- n_ld, input, 1, load N
- z_ld, input, 1, load Z
- p_ld, input, 1, load P
- mem_r_data, input, 16, asynchronous memory read data
- mem_addr, output, 16, memory address (combinational)
- mem_w_data, output, 16, equals rf_r_data_1
- rf_r_data_0, input, 16, register-file read port 0
- rf_r_data_1, input, 16, register-file read port 1
- rf_w_data, output, 16, register-file write data (combinational)
- ir, output, 16, instruction register
- pc, output, 16, program counter
- n, output, 1, condition code N
- z, output, 1, condition code Z
- p, output, 1, condition code P

Behaviour:
- Reset values (clk edge with rst=1): pc = RESET_PC, ir = 0, store register = 0, n = 0, z = 1, p = 0.
- rst has priority over every strobe.
- PC update priority: pc_clr > pc_ld > pc_inc; otherwise hold.
- PC adder: pc + sext(offset) per pc_add_sel. The adder uses the current registered PC, which already points past the instruction after fetch.
- All adds are 16-bit modulo. Overflow is ignored and wraps: 16'hFFFF + 1 = 16'h0000.
- ALU operations:
  - ADD = A + B.
  - AND = A & B.
  - PASS_A = A.
  - NOT = ~A; B is ignored.
- Sign extension replicates the top bit of the selected field to 16 bits.
- NZP update:
  - The source value V is chosen by nzp_sel.
  - On an edge with any of n_ld, z_ld or p_ld asserted, each asserted flag loads its bit of the one-hot {V[15], V==0, !V[15] && V!=0}.
  - Flags whose load is low hold their value. Control asserts all three together; partial loads are legal and must behave bitwise.
- ir_ld and pc_inc may be asserted in the same cycle (fetch):
  - ir captures mem_r_data addressed by the old PC (addr_mem_sel = 00).
  - pc becomes old PC + 1.
- store_ld together with ir_ld is legal; both capture the same mem_r_data.
- All outputs not listed above are combinational. There is no latency inside the block.
- Register state is one cycle: a strobe at edge k is visible on ir/pc/n/z/p after edge k.
- rst asserted mid-instruction discards all in-flight state; no partial update survives.

Decomposition:
- Shared package (common defines file): mux-select encodings (addr, w_rf, sext, a, b, pc_data, pc_add, nzp), ALU op codes, and the NZP reset constant 3'b010. Control and datapath both use these; local redefinition is forbidden.
- One natural sub-module: punc_alu (combinational ALU: A, B, alu_sel -> result). The PC, IR, NZP and store registers stay in punc_datapath.

Test Plan:
- Reset, then check outputs -> pc = 0000, ir = 0000, {n,z,p} = 010. Then pulse pc_clr with pc_ld=1 -> pc stays 0000.
- Fetch: pc = 0005, mem_r_data = 16'h1283, ir_ld=1, pc_inc=1, addr_mem_sel = 00 -> mem_addr = 0005 during the cycle; after the edge ir = 1283, pc = 0006.
- ADD imm: ir = 16'h1283 (imm5 = 3), rf_r_data_0 = 16'hFFFE, a_sel=1, b_sel=1, sext_sel = 00, alu_sel = 00, w_rf_sel = 10, all nzp loads -> rf_w_data = 0001; after the edge {n,z,p} = 001.
- Branch: pc = 0010, ir[8:0] = 9'h1FC (-4), pc_add_sel=1, pc_ld=1, pc_data_sel=0 -> pc = 000C. Separately, pc = FFFF with offset +1 -> pc = 0000 (wrap).
- LDI indirect: mem_r_data = 16'h3000, store_ld=1; next cycle addr_mem_sel = 10 -> mem_addr = 3000. Then mem_r_data = 8000 with nzp_sel=1 and loads -> {n,z,p} = 100.
- NOT / JMP: rf_r_data_0 = 00FF, alu_sel = 11, a_sel=1 -> rf_w_data = FF00. Then pc_data_sel=1, pc_ld=1 with rf_r_data_0 = 4000 -> pc = 4000. Also assert rst in the same cycle as pc_ld -> pc = 0000.
